// File: rtl/y86_alu.sv
// ---------------------------------------------------------------------------
// y86_alu
//   Execute-stage ALU for the Y86-64 sequential processor. Computes
//   add / sub / and / xor combinationally, derives {ZF,SF,OF} for the
//   current result, holds the architectural condition-code register and
//   evaluates the jXX / cmovXX condition from the stored codes.
//
// Ports
//   clk      in   1      clock; cc updates on the rising edge
//   rst_n    in   1      asynchronous active-low reset, clears cc
//   a        in   WIDTH  first operand (valB)
//   b        in   WIDTH  second operand (valA, valC or 8)
//   op       in   2      00 add, 01 sub (a - b), 10 and, 11 xor
//   set_cc   in   1      load cc from flags at the next rising edge
//   cond_fn  in   4      condition selector (ifun): 0..6, 7..15 never
//   result   out  WIDTH  combinational ALU result
//   flags    out  3      combinational {ZF,SF,OF} of result
//   cc       out  3      registered {ZF,SF,OF}
//   cnd      out  1      condition outcome from cc and cond_fn
// ---------------------------------------------------------------------------
module y86_alu #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    input  logic             set_cc,
    input  logic [3:0]       cond_fn,
    output logic [WIDTH-1:0] result,
    output logic [2:0]       flags,
    output logic [2:0]       cc,
    output logic             cnd
);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_XOR = 2'b11;

    // Shared adder: subtraction is a + ~b + 1, so one adder covers both.
    logic             is_sub;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] sum;

    assign is_sub = (op == OP_SUB);
    assign b_eff  = is_sub ? ~b : b;
    assign sum    = a + b_eff + {{(WIDTH-1){1'b0}}, is_sub};

    always_comb begin
        result = sum;
        case (op)
            OP_ADD:  result = sum;
            OP_SUB:  result = sum;
            OP_AND:  result = a & b;
            OP_XOR:  result = a ^ b;
            default: result = sum;
        endcase
    end

    // Flag derivation. Overflow is a sign-based rule: add overflows when
    // both operands share a sign that the result lacks; sub overflows when
    // the operands differ in sign and the result's sign differs from a.
    logic zf;
    logic sf;
    logic of;

    assign zf = (result == '0);
    assign sf = result[WIDTH-1];

    always_comb begin
        of = 1'b0;
        case (op)
            OP_ADD:  of = (a[WIDTH-1] == b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
            OP_SUB:  of = (a[WIDTH-1] != b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
            default: of = 1'b0;
        endcase
    end

    assign flags = {zf, sf, of};

    // Architectural condition codes. Only OPq raises set_cc; address and
    // move computations share the ALU without touching cc.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cc <= 3'b000;
        end else if (set_cc) begin
            cc <= flags;
        end
    end

    // Branch / cmov condition, always from the stored codes so that a
    // compare is visible to the following instruction, not the same one.
    logic cc_zf;
    logic cc_sf;
    logic cc_of;
    logic lt;

    assign cc_zf = cc[2];
    assign cc_sf = cc[1];
    assign cc_of = cc[0];
    assign lt    = cc_sf ^ cc_of;

    always_comb begin
        cnd = 1'b0;
        case (cond_fn)
            4'd0:    cnd = 1'b1;
            4'd1:    cnd = lt | cc_zf;
            4'd2:    cnd = lt;
            4'd3:    cnd = cc_zf;
            4'd4:    cnd = ~cc_zf;
            4'd5:    cnd = ~lt;
            4'd6:    cnd = ~lt & ~cc_zf;
            default: cnd = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_y86_alu.sv
// ---------------------------------------------------------------------------
// tb_y86_alu
//   Directed bench for y86_alu: reset state, arithmetic and logic vectors
//   with hand-computed results and flags, cc latch/hold, condition
//   evaluation and asynchronous reset between clock edges.
// ---------------------------------------------------------------------------
module tb_y86_alu;

    logic        clk;
    logic        clk_en;
    logic        rst_n;
    logic [63:0] a;
    logic [63:0] b;
    logic [1:0]  op;
    logic        set_cc;
    logic [3:0]  cond_fn;
    logic [63:0] result;
    logic [2:0]  flags;
    logic [2:0]  cc;
    logic        cnd;

    int checks;
    int errors;

    y86_alu #(.WIDTH(64)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .a       (a),
        .b       (b),
        .op      (op),
        .set_cc  (set_cc),
        .cond_fn (cond_fn),
        .result  (result),
        .flags   (flags),
        .cc      (cc),
        .cnd     (cnd)
    );

    // ---------------- clock ----------------
    // Held low until clk_en is raised so the reset check runs with no edge.
    initial begin
        clk = 1'b0;
        forever begin
            #5;
            if (clk_en) clk = ~clk;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [1:0] t_op, input logic [63:0] t_a,
                         input logic [63:0] t_b, input logic t_set);
        op     = t_op;
        a      = t_a;
        b      = t_b;
        set_cc = t_set;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] observed,
                         input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic check_cnd(input string tag, input logic [3:0] fn,
                             input logic expected);
        cond_fn = fn;
        #1;
        check(tag, {63'd0, cnd}, {63'd0, expected});
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        checks  = 0;
        errors  = 0;
        clk_en  = 1'b0;
        rst_n   = 1'b1;
        a       = '0;
        b       = '0;
        op      = 2'b00;
        set_cc  = 1'b1;
        cond_fn = 4'd0;

        // 1. Reset without any clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_cc", {61'd0, cc}, 64'd0);
        check_cnd("reset_cnd0", 4'd0, 1'b1);
        check_cnd("reset_cnd3", 4'd3, 1'b0);
        check_cnd("reset_cnd5", 4'd5, 1'b1);
        check_cnd("reset_cnd6", 4'd6, 1'b1);
        check_cnd("reset_cnd7", 4'd7, 1'b0);
        check_cnd("reset_cnd15", 4'd15, 1'b0);

        // 2. Arithmetic sweep (combinational, set_cc low).
        drive(2'b00, 64'd5, 64'd3, 1'b0);
        check("add_5_3_res", result, 64'd8);
        check("add_5_3_flg", {61'd0, flags}, 64'b000);
        drive(2'b01, 64'd5, 64'd5, 1'b0);
        check("sub_5_5_res", result, 64'd0);
        check("sub_5_5_flg", {61'd0, flags}, 64'b100);
        drive(2'b01, 64'd3, 64'd5, 1'b0);
        check("sub_3_5_res", result, 64'hFFFF_FFFF_FFFF_FFFE);
        check("sub_3_5_flg", {61'd0, flags}, 64'b010);
        drive(2'b01, 64'h100, 64'd8, 1'b0);
        check("sub_100_8_res", result, 64'hF8);
        drive(2'b01, 64'd0, 64'd1, 1'b0);
        check("sub_0_1_res", result, 64'hFFFF_FFFF_FFFF_FFFF);
        check("sub_0_1_flg", {61'd0, flags}, 64'b010);

        // 3. Overflow.
        drive(2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
        check("add_ovf_res", result, 64'h8000_0000_0000_0000);
        check("add_ovf_flg", {61'd0, flags}, 64'b011);
        drive(2'b01, 64'h8000_0000_0000_0000, 64'd1, 1'b0);
        check("sub_ovf_res", result, 64'h7FFF_FFFF_FFFF_FFFF);
        check("sub_ovf_flg", {61'd0, flags}, 64'b001);
        drive(2'b00, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0);
        check("add_negovf_res", result, 64'd0);
        check("add_negovf_flg", {61'd0, flags}, 64'b101);

        // 4. Logic ops.
        drive(2'b10, 64'hF0F0, 64'hFF00, 1'b0);
        check("and_res", result, 64'hF000);
        check("and_flg", {61'd0, flags}, 64'b000);
        drive(2'b11, 64'hDEAD_BEEF, 64'hDEAD_BEEF, 1'b0);
        check("xor_zero_res", result, 64'd0);
        check("xor_zero_flg", {61'd0, flags}, 64'b100);
        drive(2'b11, 64'h8000_0000_0000_0000, 64'd0, 1'b0);
        check("xor_neg_flg", {61'd0, flags}, 64'b010);
        drive(2'b10, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0);
        check("and_neg_flg", {61'd0, flags}, 64'b010);

        // Release reset away from any edge and start the clock.
        drive(2'b00, 64'd0, 64'd0, 1'b0);
        rst_n  = 1'b1;
        clk_en = 1'b1;
        tick();
        check("idle_cc", {61'd0, cc}, 64'b000);

        // 5. CC latch and hold.
        drive(2'b01, 64'd3, 64'd5, 1'b1);
        tick();
        check("latch_cc", {61'd0, cc}, 64'b010);
        check_cnd("latch_cnd2", 4'd2, 1'b1);
        check_cnd("latch_cnd1", 4'd1, 1'b1);
        check_cnd("latch_cnd6", 4'd6, 1'b0);
        check_cnd("latch_cnd4", 4'd4, 1'b1);
        check_cnd("latch_cnd5", 4'd5, 1'b0);
        check_cnd("latch_cnd3", 4'd3, 1'b0);
        drive(2'b01, 64'd7, 64'd7, 1'b0);
        tick();
        check("hold_cc", {61'd0, cc}, 64'b010);
        drive(2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1);
        tick();
        check("latch_ovf_cc", {61'd0, cc}, 64'b011);
        check_cnd("ovf_cnd2", 4'd2, 1'b0);
        check_cnd("ovf_cnd5", 4'd5, 1'b1);

        // 6. Async reset mid-operation.
        drive(2'b01, 64'd5, 64'd5, 1'b1);
        tick();
        check("pre_rst_cc", {61'd0, cc}, 64'b100);
        drive(2'b01, 64'd3, 64'd5, 1'b1);
        rst_n = 1'b0;
        #1;
        check("async_rst_cc", {61'd0, cc}, 64'b000);
        tick();
        check("rst_hold_cc", {61'd0, cc}, 64'b000);
        drive(2'b00, 64'd0, 64'd0, 1'b1);
        rst_n = 1'b1;
        #1;
        check("post_rel_cc", {61'd0, cc}, 64'b000);
        tick();
        check("post_rst_cc", {61'd0, cc}, 64'b100);
        check_cnd("post_rst_cnd3", 4'd3, 1'b1);

        // ---------------- report ----------------
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
